ov5640_stream_capture: RTL and testbench
========================================

# ov5640_stream_capture

Parametrised OV5640 DVP-to-AXI4-Stream capture engine: the next generation of the camera front end feeding the VDMA `frame_in` stream. It samples VSYNC/HREF/D on `pclk` and pairs bytes into pixels, with RGB565→RGB888 expansion or raw YUV422 passthrough. Pixels are buffered in an internal FIFO so that `tready` backpressure is honoured. Frame-start (`tuser`) and end-of-line (`tlast`) markers, frame/line counters and overflow recovery are generated internally.

## Interface
- `OUT_MODE`, 0: 0 = RGB565 in, RGB888 out; 1 = YUV422 raw 16-bit passthrough.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥4.
- `VS_POL`, 1: active level of VSYNC (1 = high during vertical blank).
- `CNT_W`, 16: width of frame/line/drop counters.
- `pclk` in 1: camera pixel clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `vsync` in 1: camera VSYNC.
- `href` in 1: camera HREF, high during active line bytes.
- `d` in 8: camera data byte.
- `m_tdata` out 32: mode 0 `{8'h00,R8,G8,B8}`; mode 1 `{16'h0000,byte0,byte1}`.
- `m_tkeep` out 4: constant 4'b1111.
- `m_tuser` out 1: first pixel of frame.
- `m_tlast` out 1: last pixel of line.
- `m_tvalid` out 1 / `m_tready` in 1: AXI4-Stream handshake.
- `status_clr` in 1: one-cycle pulse; clears `overflow` and `drop_count`.
- `frame_count` out CNT_W: completed frames, wraps.
- `line_count` out CNT_W: lines emitted in current frame; zeroed at SOF.
- `drop_count` out CNT_W: frames aborted by overflow; saturates.
- `overflow` out 1: sticky overflow flag.

## Operation
- Inputs registered once (`vs_q`, `hr_q`, `d_q`); all logic uses registered copies. `vs_act` = (`vs_q` == VS_POL).
- FSM states: WAIT_VS → WAIT_SOF → ACTIVE ⇄ DROP.
  - WAIT_VS (reset state): wait for `vs_act`=1.
  - WAIT_SOF: on `vs_act` falling → ACTIVE, arm `sof_pend`=1. Partial frames after reset are never emitted.
  - ACTIVE: capture; on push while FIFO full → DROP, `overflow`←1, `drop_count`+1 (saturating). Pixel not written.
  - DROP: discard all bytes; on `vs_act` rising → WAIT_SOF. FIFO drains normally.
- Byte pairing: phase toggles each `hr_q`=1 cycle, cleared when `hr_q`=0. Byte0 is the first byte of a pair. Odd trailing byte at line end is discarded.
- RGB expansion: R5=b0[7:3], G6={b0[2:0],b1[7:5]}, B5=b1[4:0]. R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- One-pixel lookahead register `hold` {data,user}:
  - When a new pixel completes and `hold` is valid, `hold` is pushed with last=0.
  - When `hr_q` falls with `hold` valid, `hold` is pushed with last=1, `line_count`+1.
- `user` = `sof_pend` at capture; `sof_pend` cleared when that pixel is captured. At SOF, `line_count`←0.
- `frame_count`+1 on `vs_act` rising while in ACTIVE (wraps).
- `status_clr` same cycle as an overflow event: the set wins.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tuser`=0, `m_tlast`=0, all counters 0, `overflow`=0, FSM=WAIT_VS, FIFO empty, `hold` invalid.
- Byte on `d` at edge k → in `d_q` at k+1. A pixel completes at the edge its byte1 is registered. Push into FIFO occurs at successor completion or on `hr_q` fall. `m_tvalid` rises the cycle after the push (registered FIFO output, show-ahead).
- Pop on `m_tvalid & m_tready`. Push and pop in the same cycle when full is not an overflow (pop first).
- `m_tdata/tuser/tlast` stable while `m_tvalid & !m_tready`.
- Throughput: 1 pixel per 2 `pclk`; FIFO absorbs `tready` gaps up to FIFO_DEPTH pixels.

## Structure
- Package `ov5640_cap_pkg`: OUT_MODE constants, FSM state enum, `rgb565_to_888` function, FIFO entry width (34: data+user+last).
- Sub-module `ov5640_stream_fifo`: synchronous, show-ahead, parametrised depth/width, `full`/`empty`, async active-low reset.

## Test plan
- Mode 0, 4-pixel line, bytes F8,00 / 07,E0 / 00,1F / FF,FF, `tready`=1 → tdata 00FF0000, 0000FF00, 000000FF, 00FFFFFF; tuser on first beat only; tlast on 4th; `line_count`=1.
- Mode 1, 3-pixel line of bytes 10..15 plus odd byte 16 → tdata 00001011, 00001213, 00001415; tlast on 3rd; byte 16 dropped.
- Reset mid-frame (HREF active) → no output until the full next frame; first beat has tuser=1; `frame_count` increments only at that frame's end.
- FIFO_DEPTH=4, `tready`=0, 6-pixel line → 4 beats retained, `overflow`=1, `drop_count`=1; rest of frame discarded; next frame emitted intact with tuser.
- Random `tready` (50%), two 8×3 frames → 48 beats in order, no loss, tlast every 8th, tuser on beats 0 and 24, `frame_count`=2.
- `status_clr` pulse coincident with an overflow event → `overflow` remains 1; a later lone `status_clr` → `overflow`=0, `drop_count`=0.

Source files
------------

// File: rtl/ov5640_cap_pkg.sv
// OV5640 capture shared types and helpers.
// Pixel formats, capture FSM states and FIFO entry layout.
package ov5640_cap_pkg;

  localparam int unsigned OUT_RGB888 = 0;
  localparam int unsigned OUT_YUV422 = 1;
  localparam int unsigned ENTRY_W    = 34;

  typedef enum logic [1:0] {
    ST_WAIT_VS,
    ST_WAIT_SOF,
    ST_ACTIVE,
    ST_DROP
  } cap_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } fifo_entry_t;

  function automatic logic [23:0] rgb565_to_888(
    input logic [7:0] b0,
    input logic [7:0] b1
  );
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = b0[7:3];
    g6 = {b0[2:0], b1[7:5]};
    b5 = b1[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/ov5640_stream_fifo.sv
// Show-ahead synchronous FIFO for captured pixel beats.
// Read data is forced to zero while empty so idle outputs stay clean.
module ov5640_stream_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // a full FIFO still accepts a write when a read frees a slot
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/ov5640_stream_capture.sv
// OV5640 DVP to AXI4-Stream capture with pixel FIFO,
// frame/line markers, counters and overflow recovery.
module ov5640_stream_capture
  import ov5640_cap_pkg::*;
#(
  parameter int unsigned OUT_MODE   = 0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             href,
  input  logic [7:0]       d,
  output logic [31:0]      m_tdata,
  output logic [3:0]       m_tkeep,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  input  logic             status_clr,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  cap_state_e state_q, state_d;

  logic             vs_q, hr_q, hr_prev_q, vs_act_q;
  logic [7:0]       d_q, b0_q;
  logic             phase_q, sof_pend_q;
  logic             hold_v_q, hold_user_q;
  logic [31:0]      hold_data_q;
  logic [CNT_W-1:0] frame_q, line_q, drop_q;
  logic             ovf_q;

  logic        vs_act, vs_rise, vs_fall, hr_fall, pix_done;
  logic [31:0] pix_data;
  logic        push, push_last, pop, full, empty;
  logic        cap, sof, ovf_ev, frame_inc, line_inc;
  fifo_entry_t push_entry, pop_entry;

  assign vs_act   = (vs_q == VS_POL);
  assign vs_rise  = vs_act & ~vs_act_q;
  assign vs_fall  = ~vs_act & vs_act_q;
  assign hr_fall  = hr_prev_q & ~hr_q;
  assign pix_done = hr_q & phase_q;
  assign pop      = m_tvalid & m_tready;

  always_comb begin
    if (OUT_MODE == OUT_YUV422) pix_data = {16'h0000, b0_q, d_q};
    else pix_data = {8'h00, rgb565_to_888(b0_q, d_q)};
  end

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_last = 1'b0;
    cap       = 1'b0;
    sof       = 1'b0;
    ovf_ev    = 1'b0;
    frame_inc = 1'b0;
    line_inc  = 1'b0;
    unique case (state_q)
      ST_WAIT_VS: begin
        if (vs_act) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (vs_fall) begin
          state_d = ST_ACTIVE;
          sof     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          state_d   = ST_WAIT_SOF;
          frame_inc = 1'b1;
        end else begin
          cap       = pix_done;
          push      = hold_v_q & (pix_done | hr_fall);
          push_last = hr_fall;
          // a held pixel with nowhere to go aborts the frame
          if (push && full && !pop) begin
            push    = 1'b0;
            cap     = 1'b0;
            ovf_ev  = 1'b1;
            state_d = ST_DROP;
          end else begin
            line_inc = push & hr_fall;
          end
        end
      end
      ST_DROP: begin
        if (vs_rise) state_d = ST_WAIT_SOF;
      end
      default: state_d = ST_WAIT_VS;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_WAIT_VS;
      vs_q      <= 1'b0;
      hr_q      <= 1'b0;
      d_q       <= '0;
      hr_prev_q <= 1'b0;
      vs_act_q  <= 1'b0;
      phase_q   <= 1'b0;
      b0_q      <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vsync;
      hr_q      <= href;
      d_q       <= d;
      hr_prev_q <= hr_q;
      vs_act_q  <= vs_act;
      phase_q   <= hr_q & ~phase_q;
      if (hr_q && !phase_q) b0_q <= d_q;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hold_v_q    <= 1'b0;
      hold_user_q <= 1'b0;
      hold_data_q <= '0;
      sof_pend_q  <= 1'b0;
    end else begin
      if (state_d != ST_ACTIVE) begin
        hold_v_q <= 1'b0;
      end else if (cap) begin
        hold_v_q    <= 1'b1;
        hold_data_q <= pix_data;
        hold_user_q <= sof_pend_q;
      end else if (push && push_last) begin
        hold_v_q <= 1'b0;
      end
      if (sof) sof_pend_q <= 1'b1;
      else if (cap) sof_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      line_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (frame_inc) frame_q <= frame_q + CNT_W'(1);
      if (sof) line_q <= '0;
      else if (line_inc) line_q <= line_q + CNT_W'(1);
      // an overflow in the same cycle as a clear keeps the flag set
      if (ovf_ev) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      end else if (status_clr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  assign push_entry = '{data: hold_data_q, user: hold_user_q,
                        last: push_last};

  ov5640_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (pclk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (pop_entry),
    .full_o  (full),
    .empty_o (empty)
  );

  assign m_tvalid    = ~empty;
  assign m_tdata     = pop_entry.data;
  assign m_tuser     = pop_entry.user;
  assign m_tlast     = pop_entry.last;
  assign m_tkeep     = 4'hF;
  assign frame_count = frame_q;
  assign line_count  = line_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ov5640_stream_capture.sv
// Scoreboard bench for ov5640_stream_capture: three instances
// (RGB, YUV, 4-deep RGB) share one camera byte stream.
module tb_ov5640_stream_capture;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  localparam int HB = 8;

  logic        pclk = 1'b0;
  logic        reset, vsync, href, status_clr;
  logic [7:0]  d;
  logic [1:0]  tready_ab;
  logic        tready_c;
  logic [2:0]  trdy;
  logic [31:0] tdata [3];
  logic [3:0]  tkeep [3];
  logic [2:0]  tuser, tlast, tvalid, ov;
  logic [15:0] fc [3];
  logic [15:0] lc [3];
  logic [15:0] dc [3];

  beat_t      expq [3][$];
  beat_t      mon_e;
  logic [7:0] frm [$];
  logic       clr_arm;
  logic       rand_rdy;
  int         vectors = 0;
  int         miscompares = 0;

  assign trdy = {tready_c, tready_ab};

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ov5640_stream_capture #(
      .OUT_MODE   (g == 1 ? 1 : 0),
      .FIFO_DEPTH (g == 2 ? 4 : 16),
      .VS_POL     (1'b1),
      .CNT_W      (16)
    ) u_dut (
      .pclk        (pclk),
      .reset       (reset),
      .vsync       (vsync),
      .href        (href),
      .d           (d),
      .m_tdata     (tdata[g]),
      .m_tkeep     (tkeep[g]),
      .m_tuser     (tuser[g]),
      .m_tlast     (tlast[g]),
      .m_tvalid    (tvalid[g]),
      .m_tready    (trdy[g]),
      .status_clr  (status_clr),
      .frame_count (fc[g]),
      .line_count  (lc[g]),
      .drop_count  (dc[g]),
      .overflow    (ov[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb_ref(input int b0, input int b1);
    int r5, g6, b5;
    r5 = b0 / 8;
    g6 = (b0 % 8) * 8 + b1 / 32;
    b5 = b1 % 32;
    return 32'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256
               + (b5 * 8 + b5 / 4));
  endfunction

  always @(negedge pclk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset && tvalid[i] && trdy[i]) begin
        if (expq[i].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL beat%0d: got unexpected beat %08h, expected none",
                   i, tdata[i]);
        end else begin
          mon_e = expq[i].pop_front();
          chk($sformatf("beat%0d", i),
              {26'd0, tdata[i], tuser[i], tlast[i], tkeep[i]},
              {26'd0, mon_e.data, mon_e.user, mon_e.last, 4'hF});
        end
      end
    end
  end

  initial begin
    tready_ab = 2'b11;
    forever begin
      @(posedge pclk);
      #1;
      if (rand_rdy) tready_ab = 2'($urandom_range(0, 3));
      else tready_ab = 2'b11;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic cam_cycle(input logic vs, input logic hr,
                           input logic [7:0] b);
    @(posedge pclk);
    #1;
    vsync      = vs;
    href       = hr;
    d          = b;
    status_clr = clr_arm;
    clr_arm    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) expq[i].delete();
    @(posedge pclk);
    #1;
    reset = 1'b1;
  endtask

  task automatic rand_frame(input int n);
    frm.delete();
    repeat (n) frm.push_back(8'($urandom));
  endtask

  task automatic send_frame(input int nl, input int nb, input bit exp_en,
                            input int cap_c, input int rst_at,
                            input int clr_at);
    int    n, idx, b0, b1;
    beat_t e;
    n = 0;
    if (exp_en) begin
      for (int l = 0; l < nl; l++) begin
        for (int p = 0; p < nb / 2; p++) begin
          b0     = int'(frm[l * nb + 2 * p]);
          b1     = int'(frm[l * nb + 2 * p + 1]);
          e.user = (n == 0);
          e.last = (p == nb / 2 - 1);
          e.data = rgb_ref(b0, b1);
          expq[0].push_back(e);
          if (n < cap_c) expq[2].push_back(e);
          e.data = 32'(b0 * 256 + b1);
          expq[1].push_back(e);
          n++;
        end
      end
    end
    repeat (4) cam_cycle(1'b1, 1'b0, 8'h00);
    repeat (3) cam_cycle(1'b0, 1'b0, 8'h00);
    idx = 0;
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < nb; i++) begin
        cam_cycle(1'b0, 1'b1, frm[l * nb + i]);
        if (idx == clr_at) clr_arm = 1'b1;
        if (idx == rst_at) do_reset();
        idx++;
      end
      repeat (HB) cam_cycle(1'b0, 1'b0, 8'h00);
    end
    repeat (5) cam_cycle(1'b1, 1'b0, 8'h00);
    @(negedge pclk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0
           && n < 3000) begin
      @(posedge pclk);
      n++;
    end
    chk("drain", 64'(expq[0].size() + expq[1].size() + expq[2].size()), 0);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
  endtask

  initial begin
    reset      = 1'b0;
    vsync      = 1'b1;
    href       = 1'b0;
    d          = 8'h00;
    status_clr = 1'b0;
    clr_arm    = 1'b0;
    rand_rdy   = 1'b0;
    tready_c   = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_out%0d", i),
          {27'd0, tvalid[i], tdata[i], tuser[i], tlast[i], tkeep[i]},
          {27'd0, 1'b0, 32'd0, 1'b0, 1'b0, 4'hF});
      chk($sformatf("rst_cnt%0d", i),
          {15'd0, fc[i], lc[i], dc[i], ov[i]}, 64'd0);
    end
    @(posedge pclk);
    #1;
    reset = 1'b1;

    frm = {8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    send_frame(1, 8, 1'b1, 99, -1, -1);
    wait_drain();
    chk("line_count_t1", lc[0], 1);
    chk("frame_count_t1", fc[1], 1);

    frm = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send_frame(1, 7, 1'b1, 99, -1, -1);
    wait_drain();
    chk("line_count_t2", lc[1], 1);
    chk("frame_count_t2", fc[0], 2);

    @(posedge pclk);
    #1;
    tready_c = 1'b0;
    rand_frame(12);
    send_frame(1, 12, 1'b1, 4, -1, 11);
    chk("overflow_set", ov[2], 1);
    chk("drop_count_set", dc[2], 1);
    chk("frame_count_drop", fc[2], 2);
    chk("overflow_other", ov[0], 0);
    @(posedge pclk);
    #1;
    tready_c = 1'b1;
    wait_drain();

    rand_frame(16);
    send_frame(2, 8, 1'b1, 99, -1, -1);
    wait_drain();
    chk("frame_count_recov", fc[2], 3);
    clr_arm = 1'b1;
    cam_cycle(1'b1, 1'b0, 8'h00);
    cam_cycle(1'b1, 1'b0, 8'h00);
    @(negedge pclk);
    chk("overflow_clr", ov[2], 0);
    chk("drop_count_clr", dc[2], 0);

    rand_frame(16);
    send_frame(2, 8, 1'b0, 99, 3, -1);
    wait_drain();
    chk("frame_count_rst", fc[0], 0);

    rand_rdy = 1'b1;
    rand_frame(48);
    send_frame(3, 16, 1'b1, 99, -1, -1);
    chk("frame_count_r1", fc[0], 1);
    rand_frame(48);
    send_frame(3, 16, 1'b1, 99, -1, -1);
    wait_drain();
    rand_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frame_count_r2_%0d", i), fc[i], 2);
      chk($sformatf("line_count_r2_%0d", i), lc[i], 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
